// File: rtl/mul_unit_if.sv
// Request/response bundle between the EX stage and the RV32M multiply controller.
interface mul_unit_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/mul_unit.sv
// Multi-cycle RV32M MUL/MULH/MULHSU/MULHU controller around a 32x32 unsigned multiplier.
// Optional MUL_FUSE_EN: single-entry product cache letting repeated operand pairs skip MUL/FIX.
module unsigned_mul (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);
  assign res_o = {32'd0, a_i} * {32'd0, b_i};
endmodule

module mul_unit (
  input  logic      clk,
  input  logic      rst,
  mul_unit_if.slave mif
);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        neg_q;
  logic [63:0] prod_q;
  logic [31:0] result_q;
  logic [63:0] mul_res;

  logic        sa_in, sb_in, neg_in, accept, hit;
  logic [31:0] mag_a, mag_b, sel_res;

  // Operand conditioning: magnitude only for operands the op treats as signed.
  always_comb begin
    sa_in  = (mif.op_i == OP_MULH) || (mif.op_i == OP_MULHSU);
    sb_in  = (mif.op_i == OP_MULH);
    mag_a  = (sa_in && mif.rs1_i[31]) ? (~mif.rs1_i + 32'd1) : mif.rs1_i;
    mag_b  = (sb_in && mif.rs2_i[31]) ? (~mif.rs2_i + 32'd1) : mif.rs2_i;
    neg_in = (sa_in & mif.rs1_i[31]) ^ (sb_in & mif.rs2_i[31]);
    accept = (state == S_IDLE) && mif.start_i && !mif.flush_i;
  end

  unsigned_mul u_mul (
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (mul_res)
  );

`ifdef MUL_FUSE_EN
  logic [63:0] c_prod;
  logic [31:0] c_rs1, c_rs2, rs1_q, rs2_q;
  logic        c_sa, c_sb, c_valid, sa_q, sb_q, hit_q;

  // MUL only uses the low half, which is identical for every sign class.
  assign hit = c_valid && (mif.rs1_i == c_rs1) && (mif.rs2_i == c_rs2) &&
               ((mif.op_i == OP_MUL) || ((sa_in == c_sa) && (sb_in == c_sb)));
`else
  assign hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = hit ? S_DONE : S_MUL;
      S_MUL:  state_nxt = mif.flush_i ? S_IDLE : S_FIX;
      S_FIX:  state_nxt = mif.flush_i ? S_IDLE : S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: result is driven live during DONE, then held from result_q.
  always_comb begin
    sel_res      = (op_q == OP_MUL) ? prod_q[31:0] : prod_q[63:32];
    mif.busy_o   = (state != S_IDLE);
    mif.done_o   = (state == S_DONE) && !mif.flush_i;
    mif.result_o = mif.done_o ? sel_res : result_q;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      neg_q    <= 1'b0;
      prod_q   <= 64'd0;
      result_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q  <= mif.op_i;
          a_q   <= mag_a;
          b_q   <= mag_b;
          neg_q <= neg_in;
`ifdef MUL_FUSE_EN
          if (hit) prod_q <= c_prod;
`endif
        end
        S_MUL:  prod_q <= mul_res;
        S_FIX:  if (neg_q) prod_q <= ~prod_q + 64'd1;
        default: ;
      endcase
      if (mif.done_o) result_q <= sel_res;
    end
  end

`ifdef MUL_FUSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      c_prod  <= 64'd0;
      c_rs1   <= 32'd0;
      c_rs2   <= 32'd0;
      c_sa    <= 1'b0;
      c_sb    <= 1'b0;
      c_valid <= 1'b0;
      rs1_q   <= 32'd0;
      rs2_q   <= 32'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      if (accept) begin
        rs1_q <= mif.rs1_i;
        rs2_q <= mif.rs2_i;
        sa_q  <= sa_in;
        sb_q  <= sb_in;
        hit_q <= hit;
      end
      if ((state != S_IDLE) && mif.flush_i) begin
        c_valid <= 1'b0;
      end else if (mif.done_o && !hit_q) begin
        c_prod  <= prod_q;
        c_rs1   <= rs1_q;
        c_rs2   <= rs2_q;
        c_sa    <= sa_q;
        c_sb    <= sb_q;
        c_valid <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Multi-cycle RV32M multiply controller for the M-extension instructions MUL, MULH, MULHSU and MULHU. It sits in the execute stage.
- Upstream: accepts decoded operands and the op select from the EX stage.
- Conditions the operands to magnitudes and drives the existing 32x32 unsigned_mul instance.
- Downstream: applies sign correction to the 64-bit product, selects the 32-bit result half, and returns it with a done pulse.

Parameters:
- none (widths fixed by RV32)

Ports:
- clk       input   1   core clock, rising edge
- rst       input   1   synchronous, active-high reset
- start_i   input   1   request valid; sampled only in IDLE
- op_i      input   2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- rs1_i     input   32  operand a
- rs2_i     input   32  operand b
- flush_i   input   1   abort in-flight op (pipeline flush)
- busy_o    output  1   high whenever state != IDLE
- done_o    output  1   one-cycle pulse, result_o valid
- result_o  output  32  result; held until the next done

Behaviour:
- Reset values: state=IDLE, busy_o=0, done_o=0, result_o=0. Internal operand, product and op registers are cleared.
- Reset asserted mid-operation: return to IDLE on the next edge with no done_o.
- State machine:
  - IDLE -> MUL on start_i & ~flush_i.
  - MUL -> FIX
  - FIX -> DONE
  - DONE -> IDLE
- Accept (IDLE, start_i=1), all in the same edge:
  - Latch op_i.
  - Latch |rs1_i| and |rs2_i|, where a magnitude is taken only if that operand is signed for the op: rs1 signed for MULH/MULHSU; rs2 signed for MULH only.
  - Latch neg = (sa & rs1[31]) ^ (sb & rs2[31]). MUL uses sa=sb=0.
  - A magnitude of 0x80000000 stays 0x80000000 (valid as unsigned).
- MUL: latched magnitudes feed unsigned_mul; its 64-bit res_o is registered at the end of the cycle.
- FIX: prod <= neg ? (~prod + 1) : prod, full 64-bit two's complement. Negating 0 yields 0.
- DONE:
  - done_o=1.
  - result_o = prod[31:0] for MUL, prod[63:32] otherwise.
- Latency: accept at edge N -> done_o high in cycle N+3. Next accept is possible at the edge ending DONE+1 (IDLE); throughput is 1 op per 4 cycles.
- start_i while busy_o=1: ignored, no queuing. The requester must hold start_i until it observes busy_o.
- flush_i:
  - In MUL/FIX/DONE: next state IDLE, done_o forced 0 in that cycle, result_o unchanged.
  - In IDLE with start_i: flush wins, request not accepted.
- rs1_i/rs2_i/op_i changing after accept: no effect.

Optional Feature:
- Macro: MUL_FUSE_EN
- Defined:
  - Stores the last completed corrected 64-bit product with its rs1, rs2 and sign class (sa, sb), plus a cache_valid bit.
  - An IDLE accept hits when cache_valid and rs1_i/rs2_i equal the stored values, and either (op_i==MUL) or (op_i's sa,sb equal the stored sa,sb).
  - On a hit: skip MUL/FIX; go IDLE -> DONE, done_o at N+1, result taken from the stored product.
  - cache_valid cleared by rst and by flush_i of an in-flight op; a hit does not rewrite the cache.
- Undefined: no cache; every op takes the 3-cycle path.

Test Plan:
- MULH rs1=0x80000000 rs2=0x80000000 -> done_o at N+3, result_o=0x40000000, busy_o high for cycles N+1..N+3.
- MULHSU rs1=0xFFFFFFFF rs2=0xFFFFFFFF -> result_o=0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- MUL rs1=7 rs2=0xFFFFFFFD -> result_o=0xFFFFFFEB. MULH rs1=0xFFFFFFFF rs2=1 -> result_o=0xFFFFFFFF. MULH rs1=0 rs2=0x80000000 -> 0x00000000.
- Accept a MULHU, pulse start_i in MUL state with other operands, assert flush_i in FIX -> no done_o, state IDLE, result_o keeps its previous value, the extra start is never executed.
- rst in FIX, then MUL 3*5 -> no stale done_o; result_o=0x0000000F at N+3.
- MUL_FUSE_EN: MULH a=0x12345678 b=0x9ABCDEF0, then MUL with same operands -> second done_o at N+1, result_o=0x242D2080. With the macro undefined the same sequence gives N+3 with the same value.
